// File: rtl/alu_arbiter_pkg.sv
// Shared types and defaults for the round-robin ALU arbiter.
package alu_arb_pkg;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;

   localparam int NREQ_DEFAULT = 4;

endpackage

// File: rtl/alu_addsub.sv
// Shared add/subtract ALU datapath: op=1 adds, op=0 adds the two's complement of b.
module alu_addsub #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         op,
   output logic [N-1:0] result,
   output logic         carry
);

   logic [N-1:0] b_eff;

   // The negated operand is truncated to N bits, so subtracting zero yields no carry.
   always_comb begin
      b_eff = op ? b : (~b + N'(1));
      {carry, result} = {1'b0, a} + {1'b0, b_eff};
   end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant, with wrap-around.
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic [$clog2(NREQ)-1:0] winner,
   output logic                    any_valid
);

   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0] idx;

   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(last_grant) + k) % NREQ);
         if (!any_valid && req[idx]) begin
            winner    = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one add/subtract ALU among NREQ requesters.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N    = 8,
   parameter int NREQ = NREQ_DEFAULT,
   parameter int CNTW = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*N-1:0]       req_a,
   input  logic [NREQ*N-1:0]       req_b,
   input  logic [NREQ-1:0]         req_op,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [N-1:0]            rsp_result,
   output logic                    rsp_carry,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [NREQ*CNTW-1:0]    grant_cnt
);

   localparam int IDW = $clog2(NREQ);

   alu_arb_state_t state;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] winner;
   logic           any_valid;
   logic           accept;
   logic [N-1:0]   op_a;
   logic [N-1:0]   op_b;
   logic           op_op;
   logic [IDW-1:0] op_id;
   logic [N-1:0]   alu_result;
   logic           alu_carry;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req        (req_valid),
      .last_grant (last_grant),
      .winner     (winner),
      .any_valid  (any_valid)
   );

   alu_addsub #(.N(N)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (op_op),
      .result (alu_result),
      .carry  (alu_carry)
   );

   assign accept = (state == IDLE) && any_valid;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         op_a       <= '0;
         op_b       <= '0;
         op_op      <= 1'b0;
         op_id      <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_id     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  op_a       <= req_a[winner*N +: N];
                  op_b       <= req_b[winner*N +: N];
                  op_op      <= req_op[winner];
                  op_id      <= winner;
                  last_grant <= winner;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_carry  <= alu_carry;
               rsp_id     <= op_id;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [CNTW-1:0] cnt_q [NREQ];

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else if (accept && !(&cnt_q[winner])) begin
         cnt_q[winner] <= cnt_q[winner] + CNTW'(1);
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
      assign grant_cnt[gi*CNTW +: CNTW] = cnt_q[gi];
   end
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed corner cases plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

   localparam int N    = 8;
   localparam int NREQ = 4;
   localparam int CNTW = 16;
   localparam int IDW  = 2;

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*N-1:0]    req_a;
   logic [NREQ*N-1:0]    req_b;
   logic [NREQ-1:0]      req_op;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [N-1:0]         rsp_result;
   logic                 rsp_carry;
   logic [IDW-1:0]       rsp_id;
   logic [NREQ*CNTW-1:0] grant_cnt;

   int checks = 0;
   int fails  = 0;

   int va [NREQ];
   int aa [NREQ];
   int bb [NREQ];
   int oo [NREQ];
   int lastG;
   int cntM [NREQ];

   alu_arbiter #(.N(N), .NREQ(NREQ), .CNTW(CNTW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_id     (rsp_id),
      .grant_cnt  (grant_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]      = (va[i] != 0);
         req_a[i*N +: N]   = N'(aa[i]);
         req_b[i*N +: N]   = N'(bb[i]);
         req_op[i]         = (oo[i] != 0);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      lastG = NREQ - 1;
      for (int i = 0; i < NREQ; i++) cntM[i] = 0;
   endtask

   function automatic int modelWinner();
      for (int k = 1; k <= NREQ; k++) begin
         if (va[(lastG + k) % NREQ] != 0) return (lastG + k) % NREQ;
      end
      return -1;
   endfunction

   // Arithmetic meaning of the ALU: add, or subtract with carry meaning "no borrow".
   task automatic modelAlu(input int a, input int b, input int op, output int r, output int c);
      int s;
      int m;
      m = 1 << N;
      if (op != 0)     s = a + b;
      else if (b == 0) s = a;
      else             s = a + m - b;
      r = s % m;
      c = s / m;
   endtask

   task automatic checkCounters(input string tag);
      int exp;
      for (int i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_STATS_EN
         exp = cntM[i];
`else
         exp = 0;
`endif
         checkOutput($sformatf("%s_cnt%0d", tag, i), 32'(grant_cnt[i*CNTW +: CNTW]), exp);
      end
   endtask

   task automatic randomizeInputs();
      for (int i = 0; i < NREQ; i++) begin
         va[i] = ($urandom_range(0, 9) < 6) ? 1 : 0;
         aa[i] = $urandom_range(0, 255);
         bb[i] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
         oo[i] = $urandom_range(0, 1);
      end
   endtask

   // Called at a falling edge with the FSM idle; returns at a falling edge with the FSM idle again.
   task automatic serveOne(input int hold, input bit scramble);
      int w;
      int er;
      int ec;
      #1;
      w = modelWinner();
      if (w < 0) begin
         checkOutput("idle_ready", 32'(req_ready), 0);
         @(negedge clk);
         checkOutput("idle_rsp_valid", 32'(rsp_valid), 0);
         return;
      end
      checkOutput("grant", 32'(req_ready), 32'(1 << w));
      modelAlu(aa[w], bb[w], oo[w], er, ec);
      @(negedge clk);
      lastG = w;
      if (cntM[w] < (1 << CNTW) - 1) cntM[w]++;
      checkOutput("exec_ready", 32'(req_ready), 0);
      checkOutput("exec_rsp_valid", 32'(rsp_valid), 0);
      if (scramble) begin
         randomizeInputs();
         applyStimulus();
      end
      rsp_ready = (hold == 0);
      @(negedge clk);
      checkOutput("resp_valid", 32'(rsp_valid), 1);
      checkOutput("resp_result", 32'(rsp_result), er);
      checkOutput("resp_carry", 32'(rsp_carry), ec);
      checkOutput("resp_id", 32'(rsp_id), w);
      checkOutput("resp_ready_low", 32'(req_ready), 0);
      if (hold > 0) begin
         repeat (hold - 1) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 1);
            checkOutput("hold_result", 32'(rsp_result), er);
            checkOutput("hold_carry", 32'(rsp_carry), ec);
            checkOutput("hold_id", 32'(rsp_id), w);
            checkOutput("hold_ready_low", 32'(req_ready), 0);
         end
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      checkOutput("done_valid", 32'(rsp_valid), 0);
      checkCounters("cnt");
   endtask

   task automatic clearInputs();
      for (int i = 0; i < NREQ; i++) begin
         va[i] = 0;
         aa[i] = 0;
         bb[i] = 0;
         oo[i] = 0;
      end
   endtask

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      rsp_ready = 1'b1;
      clearInputs();
      applyStimulus();
      modelReset();

      // Reset values
      reset = 1'b1;
      #1;
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("rst_result", 32'(rsp_result), 0);
      checkOutput("rst_carry", 32'(rsp_carry), 0);
      checkOutput("rst_id", 32'(rsp_id), 0);
      checkOutput("rst_ready", 32'(req_ready), 0);
      checkCounters("rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // All requesters valid: strict rotation starting at 0
      $display("[TB] round-robin rotation");
      for (int i = 0; i < NREQ; i++) begin
         va[i] = 1;
         aa[i] = $urandom_range(0, 255);
         bb[i] = $urandom_range(1, 255);
         oo[i] = $urandom_range(0, 1);
      end
      applyStimulus();
      for (int k = 0; k < 5; k++) begin
         serveOne(0, 1'b0);
         checkOutput($sformatf("rr_order%0d", k), 32'(rsp_id), order[k]);
      end
`ifdef ALU_ARB_STATS_EN
      checkOutput("rr_cnt0", 32'(grant_cnt[0*CNTW +: CNTW]), 2);
      checkOutput("rr_cnt3", 32'(grant_cnt[3*CNTW +: CNTW]), 1);
`else
      checkOutput("rr_cnt_tied", 32'(grant_cnt[0*CNTW +: CNTW]), 0);
`endif

      // Fresh reset, then directed arithmetic cases
      reset = 1'b1;
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      clearInputs();
      va[2] = 1; aa[2] = 5; bb[2] = 3; oo[2] = 0;
      applyStimulus();
      serveOne(0, 1'b0);
      checkOutput("single_result", 32'(rsp_result), 2);
      checkOutput("single_carry", 32'(rsp_carry), 1);
      checkOutput("single_id", 32'(rsp_id), 2);

      clearInputs();
      va[1] = 1; aa[1] = 200; bb[1] = 100; oo[1] = 1;
      applyStimulus();
      serveOne(0, 1'b0);
      checkOutput("ovf_result", 32'(rsp_result), 44);
      checkOutput("ovf_carry", 32'(rsp_carry), 1);

      // Subtract zero with ten cycles of backpressure
      clearInputs();
      va[3] = 1; aa[3] = 5; bb[3] = 0; oo[3] = 0;
      applyStimulus();
      serveOne(10, 1'b0);
      checkOutput("subz_result", 32'(rsp_result), 5);
      checkOutput("subz_carry", 32'(rsp_carry), 0);

      clearInputs();
      applyStimulus();
      serveOne(0, 1'b0);

      // Randomized traffic
      $display("[TB] randomized traffic");
      for (int it = 0; it < 60; it++) begin
         randomizeInputs();
         applyStimulus();
         serveOne($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Reset while an operation is in EXEC
      $display("[TB] reset during EXEC");
      for (int i = 0; i < NREQ; i++) begin
         va[i] = 1;
         aa[i] = $urandom_range(0, 255);
         bb[i] = $urandom_range(0, 255);
         oo[i] = $urandom_range(0, 1);
      end
      applyStimulus();
      #1;
      checkOutput("pre_abort_grant", 32'(req_ready), 32'(1 << modelWinner()));
      @(negedge clk);
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("abort_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("abort_idle_ready", 32'(req_ready), 1);
      checkCounters("abort");
      @(negedge clk);
      reset = 1'b0;
      serveOne(0, 1'b0);
      checkOutput("abort_next_id", 32'(rsp_id), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one instance of the team's add/subtract ALU datapath among NREQ requesters.
- Each requester holds a valid/ready request carrying operands and an op bit.
- The arbiter grants requesters round-robin, sequences one operation at a time through the ALU, and returns a registered result with the winning requester's ID on a valid/ready response channel.
- Sits between the decode/issue logic and the shared ALU in the K2 core.

Parameters:
- N, 8, operand/result width passed to the ALU.
- NREQ, 4, number of requesters (2..16).
- CNTW, 16, width of the per-requester grant counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  NREQ*N  flattened operand A; requester i at [i*N +: N]
- req_b  input  NREQ*N  flattened operand B
- req_op  input  NREQ  per-requester op; 1 = add (a+b), 0 = subtract (a+(~b+1))
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer ready
- rsp_result  output  N  ALU result
- rsp_carry  output  1  ALU carry-out (bit N of the N+1-bit sum)
- rsp_id  output  $clog2(NREQ)  index of the requester that issued the operation
- grant_cnt  output  NREQ*CNTW  flattened grant counters; driven 0 without ALU_ARB_STATS_EN

Behaviour:
- Reset values (all asynchronous):
  - state = IDLE
  - rsp_valid = 0, rsp_result = 0, rsp_carry = 0, rsp_id = 0
  - last_grant = NREQ-1, so requester 0 wins first
  - operand registers = 0, grant_cnt = 0
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first requester with req_valid=1, searching from (last_grant+1) mod NREQ upward with wrap-around.
  - req_ready[winner] = 1 combinationally; all other bits 0.
  - On the accepting edge: latch a, b, op and the winner's ID; last_grant <= winner; go to EXEC.
  - If no requester is valid: req_ready = 0 and the FSM stays in IDLE.
- EXEC:
  - The ALU sees the latched operands.
  - rsp_result, rsp_carry and rsp_id are registered; go to RESP.
- RESP:
  - rsp_valid = 1; response outputs hold stable.
  - When rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - If rsp_ready stays 0, the FSM waits indefinitely.
- req_ready is 0 in EXEC and RESP, so no request is accepted while a response is pending.
- Latency: rsp_valid is first high in the 2nd cycle after the accepting edge. Minimum throughput is one operation per 3 cycles.
- Arithmetic is exactly the ALU's:
  - Subtract with b=0 gives carry=0, because ~0+1 truncates to 0 at width N.
  - Otherwise, subtract carry=1 means no borrow.
- A requester may drop req_valid before it is granted; no state is kept for it.
- req_valid may change freely while the FSM is outside IDLE.
- Reset mid-operation aborts: the in-flight result is lost and rsp_valid drops immediately.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined:
  - grant_cnt[i] increments on every accepting edge for requester i.
  - The counter saturates at 2^CNTW-1 and clears on reset.
- When undefined:
  - No counter registers are built and grant_cnt is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Package alu_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t
  - a localparam default for NREQ
- Sub-module rr_pick is purely combinational: inputs req vector and last_grant; outputs winner index and any_valid.
- The shared ALU is instantiated unchanged, with N passed through.

Test Plan:
- Single request: requester 2 sends a=5, b=3, op=0 -> req_ready[2] high for one cycle; 2 cycles later rsp_valid=1, rsp_result=2, rsp_carry=1, rsp_id=2.
- Add with overflow, N=8: a=200, b=100, op=1 -> rsp_result=44, rsp_carry=1.
- Subtract b=0 corner: a=5, b=0, op=0 -> rsp_result=5, rsp_carry=0.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0; with ALU_ARB_STATS_EN, grant_cnt = {1,1,1,2} after 5 grants.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid stays 1 with stable outputs, req_ready stays 0; first cycle with rsp_ready=1 returns the FSM to IDLE.
- Assert reset during EXEC -> rsp_valid=0 immediately, state IDLE; next grant after release goes to requester 0.
